hazard_controller: RTL

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

---
 rtl/fullsend_pkg.sv | 37 +++
 rtl/hazard_controller_if.sv | 20 ++
 rtl/hazard_scoreboard.sv | 33 +++
 rtl/hazard_controller.sv | 84 ++++++++
 4 files changed

// File: rtl/fullsend_pkg.sv
// Shared pipeline definitions: instruction field positions, scoreboard slot type
// and the default multicycle EX occupancy.
package fullsend_pkg;

  localparam int unsigned XLEN               = 32;
  localparam int unsigned REG_W              = 5;
  localparam int unsigned MC_LATENCY_DEFAULT = 4;

  localparam int unsigned RD_LSB         = 7;
  localparam int unsigned RS1_LSB        = 15;
  localparam int unsigned RS2_LSB        = 20;
  localparam int unsigned WRITES_RD_BIT  = 6;
  localparam int unsigned MULTICYCLE_BIT = 4;
  localparam int unsigned LONG_IMM_BIT   = 2;

  typedef logic [REG_W-1:0] reg_idx_t;

  typedef struct packed {
    logic     valid;
    reg_idx_t rd;
  } sb_slot_t;

  localparam sb_slot_t SLOT_BUBBLE = '{valid: 1'b0, rd: '0};

  // Writes to x0 are architecturally discarded, so they never occupy a slot.
  function automatic sb_slot_t make_slot(input logic writes_rd, input reg_idx_t rd);
    sb_slot_t s;
    s.valid = writes_rd && (rd != '0);
    s.rd    = s.valid ? rd : '0;
    return s;
  endfunction

  function automatic logic slot_hit(input reg_idx_t src, input sb_slot_t s);
    return s.valid && (src != '0) && (s.rd == src);
  endfunction

endpackage

// File: rtl/hazard_controller_if.sv
// Decode-stage hazard handshake: instruction and redirect in, stall decisions out.
interface hazard_controller_if;
  import fullsend_pkg::*;

  logic [XLEN-1:0] if_id_ir;
  logic            branch_taken;
  logic            hazard;
  logic            stall_if;
  logic [31:0]     stall_cycles;

  modport master (
    output if_id_ir, branch_taken,
    input  hazard, stall_if, stall_cycles
  );

  modport slave (
    input  if_id_ir, branch_taken,
    output hazard, stall_if, stall_cycles
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// EX/MEM/WB destination scoreboard; EX holds and MEM takes bubbles while a
// multicycle instruction occupies EX.
module hazard_scoreboard
  import fullsend_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     hold_ex,
  input  sb_slot_t entry,
  output sb_slot_t ex_slot,
  output sb_slot_t mem_slot,
  output sb_slot_t wb_slot
);

  // NOTE: sequential state uses non-blocking assignments so every slot samples
  // the pre-edge value of its neighbour, giving a true one-edge shift.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_slot  <= SLOT_BUBBLE;
      mem_slot <= SLOT_BUBBLE;
      wb_slot  <= SLOT_BUBBLE;
    end else begin
      wb_slot <= mem_slot;
      if (hold_ex) begin
        mem_slot <= SLOT_BUBBLE;
      end else begin
        ex_slot  <= entry;
        mem_slot <= ex_slot;
      end
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// Decode-stage hazard detection: data hazards against EX/MEM, multicycle EX
// occupancy, branch squash, and a saturating stall-cycle counter.
module hazard_controller
  import fullsend_pkg::*;
#(
  parameter int unsigned MC_LATENCY = MC_LATENCY_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  hazard_controller_if.slave bus
);

  localparam logic [3:0] MC_LOAD = 4'(MC_LATENCY - 1);

  logic [XLEN-1:0] ir;
  reg_idx_t        rd, rs1, rs2;
  logic            writes_rd, multicycle, long_imm;

  assign ir         = bus.if_id_ir;
  assign rd         = ir[RD_LSB  +: REG_W];
  assign rs1        = ir[RS1_LSB +: REG_W];
  assign rs2        = ir[RS2_LSB +: REG_W];
  assign writes_rd  = ir[WRITES_RD_BIT];
  assign multicycle = ir[MULTICYCLE_BIT];
  assign long_imm   = ir[LONG_IMM_BIT];

  sb_slot_t    ex_slot, mem_slot, wb_slot, entry;
  logic [3:0]  busy;
  logic [31:0] stall_cnt;
  logic        data_hazard, struct_hazard, stall_src, hazard;

  // WB has already written the register file, so only EX and MEM can conflict.
  assign data_hazard = slot_hit(rs1, ex_slot) || slot_hit(rs1, mem_slot) ||
                       (!long_imm && (slot_hit(rs2, ex_slot) || slot_hit(rs2, mem_slot)));
  assign struct_hazard = (busy != '0);

  // Masking with reset makes the outputs reflect the cleared state while reset is held.
  assign stall_src = (data_hazard || struct_hazard) && !reset;
  assign hazard    = stall_src || bus.branch_taken;

  assign bus.hazard       = hazard;
  assign bus.stall_if     = stall_src && !bus.branch_taken;
  assign bus.stall_cycles = stall_cnt;

  // NOTE: every signal assigned in always_comb gets a default first so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    entry = SLOT_BUBBLE;
    if (!hazard) entry = make_slot(writes_rd, rd);
  end

  hazard_scoreboard u_sb (
    .clk      (clk),
    .reset    (reset),
    .hold_ex  (struct_hazard),
    .entry    (entry),
    .ex_slot  (ex_slot),
    .mem_slot (mem_slot),
    .wb_slot  (wb_slot)
  );

  // A multicycle instruction only enters EX when decode actually issues it.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= '0;
    end else if (busy != '0) begin
      busy <= busy - 4'd1;
    end else if (!hazard && multicycle) begin
      busy <= MC_LOAD;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (hazard && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{ir[31:25], ir[14:12], ir[5], ir[3], ir[1:0], wb_slot};

endmodule
